// File: rtl/alu_result_stage.sv
// Result stage behind the ALU: a 2-entry skid buffer with valid/ready on both sides.
// Commits each entry's flags to the status register and counts div/mod-by-zero exceptions.
module alu_result_stage #(
  parameter int WIDTH = 32,
  parameter int REGW  = 5
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [WIDTH-1:0] in_result,
  input  logic                    in_V,
  input  logic                    in_C,
  input  logic                    in_Z,
  input  logic                    in_S,
  input  logic [2:0]              in_ALUOp,
  input  logic                    in_b_zero,
  input  logic [REGW-1:0]         in_rd,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [WIDTH-1:0] out_result,
  output logic [REGW-1:0]         out_rd,
  output logic                    out_exc,
  output logic [3:0]              flags,
  output logic [7:0]              exc_count
);

  localparam logic [1:0] S_EMPTY = 2'd0;
  localparam logic [1:0] S_ONE   = 2'd1;
  localparam logic [1:0] S_FULL  = 2'd2;

  function automatic logic is_div_by_zero(input logic [2:0] op, input logic b_zero);
    return ((op == 3'd3) || (op == 3'd7)) && b_zero;
  endfunction

  function automatic logic [7:0] sat_inc8(input logic [7:0] cnt);
    return (cnt == 8'hFF) ? cnt : cnt + 8'd1;
  endfunction

  logic [1:0]              r_state;
  logic signed [WIDTH-1:0] r_hd_result_p1;
  logic [REGW-1:0]         r_hd_rd_p1;
  logic                    r_hd_exc_p1;
  logic [3:0]              r_hd_flags_p1;
  logic signed [WIDTH-1:0] r_sk_result_p1;
  logic [REGW-1:0]         r_sk_rd_p1;
  logic                    r_sk_exc_p1;
  logic [3:0]              r_sk_flags_p1;
  logic [3:0]              r_flags;
  logic [7:0]              r_exc_count;

  logic                    w_exc_p0;
  logic                    w_arith_p0;
  logic signed [WIDTH-1:0] w_result_p0;
  logic [3:0]              w_flags_p0;
  logic                    w_push;
  logic                    w_pop;

  // Capture stage (p0): classify the incoming ALU result
  assign w_exc_p0    = is_div_by_zero(in_ALUOp, in_b_zero);
  assign w_arith_p0  = (in_ALUOp == 3'd0) || (in_ALUOp == 3'd1);
  assign w_result_p0 = w_exc_p0 ? '0 : in_result;
  assign w_flags_p0  = {in_V & w_arith_p0, in_C & w_arith_p0, in_Z, in_S};

  assign in_ready  = (r_state != S_FULL) && !reset;
  assign out_valid = (r_state != S_EMPTY);
  assign w_push    = in_valid && in_ready;
  assign w_pop     = out_valid && out_ready;

  // Buffer stage (p1): head drives the outputs, skid catches one entry under backpressure
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state        <= S_EMPTY;
      r_hd_result_p1 <= '0;
      r_hd_rd_p1     <= '0;
      r_hd_exc_p1    <= 1'b0;
      r_hd_flags_p1  <= 4'b0000;
      r_flags        <= 4'b0000;
      r_exc_count    <= 8'd0;
    end else begin
      case (r_state)
        S_EMPTY: begin
          if (w_push) begin
            r_hd_result_p1 <= w_result_p0;
            r_hd_rd_p1     <= in_rd;
            r_hd_exc_p1    <= w_exc_p0;
            r_hd_flags_p1  <= w_flags_p0;
            r_state        <= S_ONE;
          end
        end
        S_ONE: begin
          if (w_push && w_pop) begin
            r_hd_result_p1 <= w_result_p0;
            r_hd_rd_p1     <= in_rd;
            r_hd_exc_p1    <= w_exc_p0;
            r_hd_flags_p1  <= w_flags_p0;
          end else if (w_push) begin
            r_state <= S_FULL;
          end else if (w_pop) begin
            r_state <= S_EMPTY;
          end
        end
        S_FULL: begin
          if (w_pop) begin
            r_hd_result_p1 <= r_sk_result_p1;
            r_hd_rd_p1     <= r_sk_rd_p1;
            r_hd_exc_p1    <= r_sk_exc_p1;
            r_hd_flags_p1  <= r_sk_flags_p1;
            r_state        <= S_ONE;
          end
        end
        default: r_state <= S_EMPTY;
      endcase
      if (w_pop) begin
        if (r_hd_exc_p1) r_exc_count <= sat_inc8(r_exc_count);
        else             r_flags     <= r_hd_flags_p1;
      end
    end
  end

  // Skid data is only ever read after being written in FULL, so it needs no reset
  always_ff @(posedge clk) begin
    if ((r_state == S_ONE) && w_push && !w_pop) begin
      r_sk_result_p1 <= w_result_p0;
      r_sk_rd_p1     <= in_rd;
      r_sk_exc_p1    <= w_exc_p0;
      r_sk_flags_p1  <= w_flags_p0;
    end
  end

  assign out_result = r_hd_result_p1;
  assign out_rd     = r_hd_rd_p1;
  assign out_exc    = r_hd_exc_p1;
  assign flags      = r_flags;
  assign exc_count  = r_exc_count;

endmodule

// File: tb/tb_alu_result_stage.sv
// Directed bench for alu_result_stage with hand-computed expected values.
module tb_alu_result_stage;
  logic               clk = 1'b0;
  logic               reset;
  logic               in_valid;
  logic               in_ready;
  logic signed [31:0] in_result;
  logic               in_V, in_C, in_Z, in_S;
  logic [2:0]         in_ALUOp;
  logic               in_b_zero;
  logic [4:0]         in_rd;
  logic               out_valid;
  logic               out_ready;
  logic signed [31:0] out_result;
  logic [4:0]         out_rd;
  logic               out_exc;
  logic [3:0]         flags;
  logic [7:0]         exc_count;

  int n_cmp = 0;
  int n_bad = 0;

  alu_result_stage #(.WIDTH(32), .REGW(5)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_result(in_result),
    .in_V(in_V), .in_C(in_C), .in_Z(in_Z), .in_S(in_S),
    .in_ALUOp(in_ALUOp), .in_b_zero(in_b_zero), .in_rd(in_rd),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_rd(out_rd), .out_exc(out_exc), .flags(flags), .exc_count(exc_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] res, input logic [2:0] op,
                       input logic [3:0] vczs, input logic bz, input logic [4:0] rd);
    in_valid  = v;
    in_result = res;
    in_ALUOp  = op;
    {in_V, in_C, in_Z, in_S} = vczs;
    in_b_zero = bz;
    in_rd     = rd;
  endtask

  initial begin
    reset = 1'b1;
    out_ready = 1'b0;
    drive(1'b0, 32'd0, 3'd0, 4'b0000, 1'b0, 5'd0);
    tick(); tick();
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_result", out_result, 32'd0);
    chk("rst_out_rd", {27'd0, out_rd}, 32'd0);
    chk("rst_out_exc", {31'd0, out_exc}, 32'd0);
    chk("rst_flags", {28'd0, flags}, 32'd0);
    chk("rst_exc_count", {24'd0, exc_count}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
    reset = 1'b0;
    #1;
    chk("post_rst_in_ready", {31'd0, in_ready}, 32'd1);

    // Single add: latency 1, flags committed on pop
    out_ready = 1'b1;
    drive(1'b1, 32'd5, 3'd0, 4'b0100, 1'b0, 5'd3);
    tick();
    drive(1'b0, 32'd0, 3'd0, 4'b0000, 1'b0, 5'd0);
    chk("add_valid", {31'd0, out_valid}, 32'd1);
    chk("add_result", out_result, 32'd5);
    chk("add_rd", {27'd0, out_rd}, 32'd3);
    chk("add_flags_pre", {28'd0, flags}, 32'd0);
    tick();
    chk("add_flags", {28'd0, flags}, 32'h4);
    chk("add_drained", {31'd0, out_valid}, 32'd0);

    // Backpressure: two fill the buffer, third is refused until a pop
    out_ready = 1'b0;
    drive(1'b1, 32'd1, 3'd4, 4'b0000, 1'b0, 5'd1);
    tick();
    chk("bp_ready_one", {31'd0, in_ready}, 32'd1);
    drive(1'b1, 32'd2, 3'd4, 4'b0000, 1'b0, 5'd2);
    tick();
    chk("bp_ready_full", {31'd0, in_ready}, 32'd0);
    drive(1'b1, 32'd3, 3'd4, 4'b0000, 1'b0, 5'd3);
    tick();
    chk("bp_hold_result", out_result, 32'd1);
    chk("bp_hold_rd", {27'd0, out_rd}, 32'd1);
    chk("bp_still_full", {31'd0, in_ready}, 32'd0);
    out_ready = 1'b1;
    tick();
    chk("bp_out2", out_result, 32'd2);
    chk("bp_out2_rd", {27'd0, out_rd}, 32'd2);
    tick();
    drive(1'b0, 32'd0, 3'd0, 4'b0000, 1'b0, 5'd0);
    chk("bp_out3", out_result, 32'd3);
    chk("bp_out3_valid", {31'd0, out_valid}, 32'd1);
    tick();
    chk("bp_drained", {31'd0, out_valid}, 32'd0);

    // Set flags to 0001, then a div-by-zero must leave them alone
    drive(1'b1, 32'hFFFF_FFFF, 3'd0, 4'b0001, 1'b0, 5'd4);
    tick();
    drive(1'b0, 32'd0, 3'd0, 4'b0000, 1'b0, 5'd0);
    tick();
    chk("pre_div_flags", {28'd0, flags}, 32'h1);
    drive(1'b1, 32'h1234_5678, 3'd3, 4'b1111, 1'b1, 5'd7);
    tick();
    drive(1'b0, 32'd0, 3'd0, 4'b0000, 1'b0, 5'd0);
    chk("div0_result", out_result, 32'd0);
    chk("div0_exc", {31'd0, out_exc}, 32'd1);
    chk("div0_rd", {27'd0, out_rd}, 32'd7);
    tick();
    chk("div0_flags", {28'd0, flags}, 32'h1);
    chk("div0_count", {24'd0, exc_count}, 32'd1);

    // Logical op: V/C masked
    drive(1'b1, 32'd0, 3'd6, 4'b1110, 1'b0, 5'd8);
    tick();
    drive(1'b0, 32'd0, 3'd0, 4'b0000, 1'b0, 5'd0);
    tick();
    chk("xor_flags", {28'd0, flags}, 32'h2);

    // mod with nonzero divisor is an ordinary result
    drive(1'b1, 32'd9, 3'd7, 4'b1101, 1'b0, 5'd9);
    tick();
    drive(1'b0, 32'd0, 3'd0, 4'b0000, 1'b0, 5'd0);
    chk("mod_result", out_result, 32'd9);
    chk("mod_exc", {31'd0, out_exc}, 32'd0);
    tick();
    chk("mod_flags", {28'd0, flags}, 32'h1);
    chk("mod_count", {24'd0, exc_count}, 32'd1);

    // 300 back-to-back mod-by-zero commits: 1 + 300 saturates at 255
    drive(1'b1, 32'd77, 3'd7, 4'b0000, 1'b1, 5'd1);
    for (int i = 0; i < 300; i++) begin
      tick();
      if (i == 100) chk("sat_mid_count", {24'd0, exc_count}, 32'd101);
    end
    drive(1'b0, 32'd0, 3'd0, 4'b0000, 1'b0, 5'd0);
    tick();
    chk("sat_count", {24'd0, exc_count}, 32'd255);
    chk("sat_flags", {28'd0, flags}, 32'h1);
    chk("sat_drained", {31'd0, out_valid}, 32'd0);

    // Fill to FULL, then reset discards everything
    out_ready = 1'b0;
    drive(1'b1, 32'd11, 3'd0, 4'b1010, 1'b0, 5'd2);
    tick(); tick();
    chk("full_ready", {31'd0, in_ready}, 32'd0);
    drive(1'b0, 32'd0, 3'd0, 4'b0000, 1'b0, 5'd0);
    reset = 1'b1;
    tick();
    chk("mid_rst_valid", {31'd0, out_valid}, 32'd0);
    chk("mid_rst_flags", {28'd0, flags}, 32'd0);
    chk("mid_rst_count", {24'd0, exc_count}, 32'd0);
    chk("mid_rst_ready", {31'd0, in_ready}, 32'd0);
    reset = 1'b0;
    tick();
    chk("after_rst_ready", {31'd0, in_ready}, 32'd1);
    chk("after_rst_valid", {31'd0, out_valid}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
